// File: rtl/count_initiator_if.sv
// Handshake bundle between the sequencer/Control side and count_initiator.
// master = sequencer + Control, slave = count_initiator.
interface count_initiator_if #(
  parameter int CNT_W = 16,
  parameter int RND_W = 8
);
  logic             start;
  logic             abort;
  logic [RND_W-1:0] num_rounds;
  logic             ready;
  logic             counting;
  logic             busy;
  logic             done;
  logic             err;
  logic [RND_W-1:0] rounds_done;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] max_latency;

  modport master (
    output start, abort, num_rounds, ready,
    input  counting, busy, done, err, rounds_done, last_latency, max_latency
  );

  modport slave (
    input  start, abort, num_rounds, ready,
    output counting, busy, done, err, rounds_done, last_latency, max_latency
  );
endinterface

// File: rtl/count_initiator.sv
// Initiator of the counting/ready handshake: runs N request rounds, measures ready latency, flags timeouts.
// Outputs registered (counting follows state by 1 cycle); no backpressure, start is ignored while busy.
module count_initiator #(
  parameter int CNT_W      = 16,
  parameter int RND_W      = 8,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  count_initiator_if.slave  bus
);

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic             ready_q;
  logic             rise;
  logic [RND_W-1:0] num_q;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] lat_inc;
  logic [GAP_W-1:0] gap_cnt;
  logic [RND_W-1:0] rounds_inc;

  logic             counting_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [RND_W-1:0] rounds_r;
  logic [CNT_W-1:0] last_r;
  logic [CNT_W-1:0] max_r;

  // A round only completes on a fresh low-to-high transition of ready.
  assign rise       = bus.ready & ~ready_q;
  assign lat_inc    = lat_cnt + 1'b1;
  assign rounds_inc = rounds_r + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ready_q    <= 1'b0;
      num_q      <= '0;
      lat_cnt    <= '0;
      gap_cnt    <= '0;
      counting_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rounds_r   <= '0;
      last_r     <= '0;
      max_r      <= '0;
    end else begin
      ready_q <= bus.ready;
      done_r  <= 1'b0;

      if (bus.abort) begin
        // Results are left intact so software can inspect the aborted run.
        state      <= S_IDLE;
        counting_r <= 1'b0;
        busy_r     <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
              num_q    <= bus.num_rounds;
              rounds_r <= '0;
              max_r    <= '0;
              err_r    <= 1'b0;
              if (bus.num_rounds != '0) begin
                state      <= S_REQ;
                counting_r <= 1'b1;
                busy_r     <= 1'b1;
                lat_cnt    <= '0;
              end else begin
                state      <= S_DONE;
                done_r     <= 1'b1;
                counting_r <= 1'b0;
                busy_r     <= 1'b0;
              end
            end
          end

          S_REQ: begin
            if (rise) begin
              // A rise on the timeout cycle still counts as a good round.
              last_r <= lat_inc;
              if (lat_inc > max_r) begin
                max_r <= lat_inc;
              end
              if (rounds_r != num_q) begin
                rounds_r <= rounds_inc;
              end
              if (rounds_inc == num_q) begin
                state      <= S_DONE;
                done_r     <= 1'b1;
                counting_r <= 1'b0;
                busy_r     <= 1'b0;
              end else if (GAP_CYCLES > 0) begin
                state      <= S_GAP;
                counting_r <= 1'b0;
                gap_cnt    <= '0;
              end else begin
                lat_cnt <= '0;
              end
            end else if (lat_cnt == LAT_LAST) begin
              state      <= S_ERR;
              err_r      <= 1'b1;
              counting_r <= 1'b0;
              busy_r     <= 1'b0;
            end else begin
              lat_cnt <= lat_inc;
            end
          end

          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state      <= S_REQ;
              counting_r <= 1'b1;
              lat_cnt    <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end

          default: begin
            state      <= S_IDLE;
            counting_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.counting     = counting_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
  assign bus.rounds_done  = rounds_r;
  assign bus.last_latency = last_r;
  assign bus.max_latency  = max_r;

endmodule

// File: tb/tb_count_initiator.sv
// Directed bench for count_initiator: bench plays sequencer and Control, checks results against hand-computed values.
module tb_count_initiator;

  localparam int CNT_W = 16;
  localparam int RND_W = 8;
  localparam int TMO   = 16;
  localparam int GAP   = 2;

  logic clk;
  logic rst;

  count_initiator_if #(.CNT_W(CNT_W), .RND_W(RND_W)) bus ();

  count_initiator #(
    .CNT_W(CNT_W), .RND_W(RND_W), .TIMEOUT(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Activity monitor, sampled on the falling edge.
  logic mon_clr = 1'b0;
  int hi_cnt, done_cnt, gap_n, gap_bad, low_run;
  bit seen_hi;

  always @(negedge clk) begin
    if (mon_clr) begin
      hi_cnt = 0; done_cnt = 0; gap_n = 0; gap_bad = 0; low_run = 0; seen_hi = 0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.counting) begin
        if (seen_hi && low_run > 0) begin
          gap_n++;
          if (low_run != GAP) gap_bad++;
        end
        seen_hi = 1;
        low_run = 0;
        hi_cnt++;
      end else begin
        low_run++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input int rounds);
    bus.num_rounds = RND_W'(rounds);
    bus.start      = 1'b1;
    tick(1);
    bus.start      = 1'b0;
  endtask

  task automatic wait_hi(input string tag);
    int n = 0;
    while (!bus.counting && n < 50) begin
      tick(1);
      n++;
    end
    if (!bus.counting) check({tag, "_wait_counting"}, bus.counting, 1);
  endtask

  // Leaves ready high only for the edge that ends REQ cycle lat.
  task automatic do_round(input string tag, input int lat);
    wait_hi(tag);
    tick(lat - 1);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_rounds = '0;
    bus.ready      = 1'b0;
    tick(3);
    check("rst_counting", bus.counting, 0);
    check("rst_busy",     bus.busy, 0);
    check("rst_done",     bus.done, 0);
    check("rst_err",      bus.err, 0);
    check("rst_rounds",   bus.rounds_done, 0);
    check("rst_last",     bus.last_latency, 0);
    check("rst_max",      bus.max_latency, 0);
    rst = 1'b1;
    tick(2);

    // Single round, latency 5.
    clear_mon();
    pulse_start(1);
    check("single_busy", bus.busy, 1);
    do_round("single", 5);
    tick(3);
    check("single_last",   bus.last_latency, 5);
    check("single_max",    bus.max_latency, 5);
    check("single_rounds", bus.rounds_done, 1);
    check("single_hi",     hi_cnt, 5);
    check("single_done",   done_cnt, 1);
    check("single_err",    bus.err, 0);
    check("single_busy_end", bus.busy, 0);

    // Three rounds 3,7,4 with a start pulse while busy that must be ignored.
    clear_mon();
    pulse_start(3);
    do_round("multi1", 3);
    pulse_start(9);
    do_round("multi2", 7);
    do_round("multi3", 4);
    tick(3);
    check("multi_last",    bus.last_latency, 4);
    check("multi_max",     bus.max_latency, 7);
    check("multi_rounds",  bus.rounds_done, 3);
    check("multi_done",    done_cnt, 1);
    check("multi_hi",      hi_cnt, 14);
    check("multi_gaps",    gap_n, 2);
    check("multi_gap_len", gap_bad, 0);

    // Ready never rises: timeout after TMO cycles of counting.
    clear_mon();
    pulse_start(2);
    tick(30);
    check("tmo_err",      bus.err, 1);
    check("tmo_hi",       hi_cnt, TMO);
    check("tmo_rounds",   bus.rounds_done, 0);
    check("tmo_done",     done_cnt, 0);
    check("tmo_counting", bus.counting, 0);
    check("tmo_busy",     bus.busy, 0);
    pulse_start(1);
    check("tmo_err_clr",  bus.err, 0);
    do_round("tmo_recover", 2);
    tick(2);
    check("tmo_recover_last", bus.last_latency, 2);

    // Rise on the very cycle that would time out: the round completes.
    clear_mon();
    pulse_start(1);
    do_round("edge", TMO);
    tick(3);
    check("edge_last", bus.last_latency, TMO);
    check("edge_err",  bus.err, 0);
    check("edge_done", done_cnt, 1);

    // Ready already high at REQ entry: drop in cycle 4, raise in cycle 6.
    clear_mon();
    bus.ready = 1'b1;
    tick(2);
    pulse_start(1);
    wait_hi("stuck");
    tick(3);
    bus.ready = 1'b0;
    tick(2);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    tick(3);
    check("stuck_last", bus.last_latency, 6);
    check("stuck_hi",   hi_cnt, 6);
    check("stuck_done", done_cnt, 1);

    // Abort during round 2 of 4.
    clear_mon();
    pulse_start(4);
    do_round("abort1", 3);
    wait_hi("abort2");
    tick(1);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("abort_counting", bus.counting, 0);
    check("abort_busy",     bus.busy, 0);
    check("abort_rounds",   bus.rounds_done, 1);
    check("abort_last",     bus.last_latency, 3);
    tick(4);
    check("abort_idle",     bus.counting, 0);
    check("abort_done",     done_cnt, 0);

    // Asynchronous reset in the middle of a REQ cycle.
    pulse_start(2);
    wait_hi("areset");
    #3;
    rst = 1'b0;
    #1;
    check("areset_counting", bus.counting, 0);
    check("areset_busy",     bus.busy, 0);
    check("areset_last",     bus.last_latency, 0);
    check("areset_max",      bus.max_latency, 0);
    check("areset_err",      bus.err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // Zero rounds: done pulse without ever raising counting.
    clear_mon();
    pulse_start(0);
    tick(4);
    check("zero_done",   done_cnt, 1);
    check("zero_hi",     hi_cnt, 0);
    check("zero_rounds", bus.rounds_done, 0);
    check("zero_busy",   bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_initiator.md
Name: count_initiator

Overview:
- Initiator side of the counting/ready handshake: drives `counting` into the Control block and waits for its `ready` rising edge.
- Runs a programmable number of request rounds and measures handshake latency per round (last and max).
- Detects a non-responding counter (timeout) and reports it.
- Sits between the top-level test sequencer/CPU-side register file and the Control block.

Parameters:
- CNT_W, 16, width of latency counters and latency outputs
- RND_W, 8, width of num_rounds and rounds_done
- TIMEOUT, 1024, maximum cycles allowed in REQ before error; range 2..2^CNT_W-1
- GAP_CYCLES, 2, idle cycles with counting low between rounds; 0 allowed

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- start  in  1  level; sampled in IDLE/DONE/ERR to begin a run
- abort  in  1  synchronous; forces return to IDLE
- num_rounds  in  RND_W  rounds per run, latched on accepted start
- ready  in  1  from Control, synchronous to clk
- counting  out  1  request to Control, registered
- busy  out  1  high in REQ/GAP
- done  out  1  one-cycle pulse when run completes
- err  out  1  sticky timeout flag
- rounds_done  out  RND_W  completed rounds in current/last run
- last_latency  out  CNT_W  latency of most recent round
- max_latency  out  CNT_W  maximum latency in current/last run

Behaviour:
- Reset (rst==0, async): state=IDLE; counting=0, busy=0, done=0, err=0; rounds_done=0, last_latency=0, max_latency=0; ready_q=0.
- Edge detect: ready_q<=ready every cycle in all states; rise = ready & ~ready_q.
  - If ready is already high on REQ entry, the round waits for a low-then-high transition.
- States: IDLE, REQ, GAP, DONE, ERR. All outputs are registered, so counting follows the state with 1 cycle of latency.
- IDLE/DONE/ERR, start==1:
  - Latch num_rounds; clear rounds_done, max_latency, err.
  - If num_rounds!=0: go to REQ.
  - If num_rounds==0: go to DONE with done pulse next cycle; counting never asserted.
- REQ:
  - counting=1, busy=1.
  - lat_cnt is cleared on REQ entry and increments each cycle without rise.
  - On rise:
    - last_latency<=lat_cnt+1 (rise on first REQ cycle gives 1).
    - max_latency<=max(max_latency, lat_cnt+1).
    - rounds_done+=1.
    - If rounds_done+1==num_rounds: go to DONE, else go to GAP (or REQ directly if GAP_CYCLES==0).
  - Timeout: if lat_cnt+1==TIMEOUT with no rise, go to ERR. err<=1, counting<=0, rounds_done unchanged.
- GAP: counting=0, busy=1 for exactly GAP_CYCLES cycles, then REQ. A rise during GAP is ignored.
- DONE: done=1 for the single cycle after entry only; counting=0, busy=0; results held until next accepted start.
- ERR: err held until accepted start or reset; counting=0.
- abort (any state): next state IDLE; counting=0, busy=0; no done pulse; result registers hold their values. abort has priority over rise and timeout in the same cycle.
- Simultaneous rise and timeout cycle: the rise wins and the round completes normally.
- start while busy is ignored; num_rounds changes after latch are ignored.
- rounds_done saturates at num_rounds; lat_cnt saturates at TIMEOUT-1.
- Reset mid-operation drops counting to 0 immediately (async).

Test Plan:
- Single round: reset, num_rounds=1, start, Control model raises ready 5 cycles after counting → counting high 5 cycles, last_latency=5, max_latency=5, rounds_done=1, one done pulse, err=0.
- Multi-round: num_rounds=3, ready latencies 3,7,4, GAP_CYCLES=2 → counting low exactly 2 cycles between rounds, last_latency=4, max_latency=7, rounds_done=3, done once.
- Timeout: TIMEOUT=16, ready never rises → counting drops after 16 REQ cycles, err=1, rounds_done=0, no done; a new start clears err.
- ready stuck high at REQ entry: ready=1 before start, dropped at cycle 4, raised at cycle 6 → round completes with last_latency=6.
- Abort: abort in round 2 of 4 → IDLE next cycle, counting=0, rounds_done=1, no done pulse.
- Async reset: assert rst=0 mid-REQ between clock edges → counting=0 and all outputs cleared before the next clk edge; num_rounds=0 start → done pulse, counting never high.
